button_event_arbiter: RTL and testbench
=======================================

# button_event_arbiter

Sequencing controller behind the per-button debouncer instances: takes the debounced levels of up to NUM_BTN buttons, detects presses, serves one button at a time by fixed-priority (or round-robin) arbitration, classifies each press as short or long, and hands one event at a time to the stopwatch control logic over a valid/ready handshake. Also maintains the pause toggle state driven by short presses of one designated button.

## Interface
- NUM_BTN, 4, number of button inputs (2..8)
- ID_W, 2, width of evt_id; must satisfy 2^ID_W >= NUM_BTN
- CNT_W, 27, hold-counter width
- LONG_CYCLES, 100000000, hold length in clk cycles that makes a press long; 2 <= LONG_CYCLES < 2^CNT_W
- PAUSE_ID, 1, index of the button whose short press toggles pause_state

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- btn_db  in  NUM_BTN  debounced button levels (debouncer outputs, already in clk domain), 1 = pressed
- evt_ready  in  1  consumer accepts event when high with evt_valid
- evt_valid  out  1  event available; registered
- evt_id  out  ID_W  index of the button for this event
- evt_long  out  1  1 = long press, 0 = short press
- pause_state  out  1  toggle state, flips on accepted short event of PAUSE_ID
- busy  out  1  high whenever FSM is not IDLE
- ovf  out  1  one-cycle pulse: press detected on a button already pending (coalesced)

## Operation
- Edge detect: prev[i] registers btn_db[i]; rise[i] = btn_db[i] & ~prev[i]. prev resets to all ones, so a button held through reset yields no event until released and re-pressed.
- pending[i] <= pending[i] | rise[i], cleared only when button i is granted. rise[i] while pending[i]=1: ovf=1 that cycle, pending stays 1.
- States: IDLE, TRACK, EMIT, WAIT_REL.
- IDLE: if any pending bit set, grant the selected button: store grant index, clear its pending bit, counter <= 0, go TRACK. Otherwise stay.
- TRACK: if btn_db[grant]=0: evt_long <= 0, go EMIT. Else if counter == LONG_CYCLES-1: evt_long <= 1, go EMIT. Else counter <= counter+1. Release takes precedence over long on the same cycle.
- EMIT: evt_valid=1, evt_id=grant; evt_valid/evt_id/evt_long stable until evt_valid & evt_ready. On handshake: long -> WAIT_REL, short -> IDLE; short with grant==PAUSE_ID toggles pause_state on the same edge.
- WAIT_REL: stay until btn_db[grant]=0, then IDLE. No event on the release.
- Pending bits of other buttons keep accumulating in every state; a rise coincident with a grant edge is retained.
- Counter never wraps: LONG_CYCLES bound guarantees exit before 2^CNT_W-1.

## Timing
- Reset: evt_valid=0, evt_id=0, evt_long=0, pause_state=0, busy=0, ovf=0, pending=0, prev=all ones, counter=0, state=IDLE, last_grant=NUM_BTN-1.
- rise sampled at edge k -> pending set at edge k -> grant at edge k+1 -> busy high after k+1.
- Long press: evt_valid rises exactly LONG_CYCLES edges after the grant edge if button held throughout.
- Short press: btn_db low sampled in TRACK at edge m -> evt_valid high after edge m.
- Handshake edge -> next grant no earlier than one cycle later (IDLE visited for one cycle minimum).
- rst mid-operation: pending events, in-flight event and pause_state discarded immediately.

## Configuration
- BTN_ARB_ROUND_ROBIN_EN defined: search starts at (last_grant+1) mod NUM_BTN, wrapping; last_grant updated on each grant.
- Not defined: fixed priority, lowest pending index wins; last_grant register absent.

## Test plan
- LONG_CYCLES=8: press btn 2 for 3 cycles, evt_ready=1 -> one event id=2, long=0; pause_state unchanged.
- LONG_CYCLES=8: hold btn 0 for 20 cycles -> evt_valid 8 cycles after grant, id=0, long=1; no second event on release; busy drops after release.
- Short press btn 1 (PAUSE_ID) twice with evt_ready=1 -> pause_state 0->1->0; with evt_ready held 0 for 5 cycles -> evt_valid/id/long stable, pause_state toggles only at handshake.
- Press btns 3 and 1 on same cycle, then btn 0 while serving -> fixed priority order 1,0,3; with BTN_ARB_ROUND_ROBIN_EN and last_grant=1 -> order 3,0 after 1.
- Re-press btn 2 twice while btn 0 is being tracked -> ovf pulses once, only one btn 2 event.
- Hold btn 3 through rst deassertion -> no event; release and press -> one event. Assert rst in EMIT -> evt_valid=0 next cycle, pending cleared.

Source files
------------

// File: rtl/button_event_arbiter_if.sv
// button_event_arbiter_if: valid/ready event channel from the button arbiter to the stopwatch control
// Signals:
//   evt_valid  event available (driven by master)
//   evt_ready  consumer accepts event (driven by slave)
//   evt_id     index of the button for this event
//   evt_long   1 = long press, 0 = short press
interface button_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_long;
    modport master(output evt_valid, evt_id, evt_long, input evt_ready);
    modport slave(input evt_valid, evt_id, evt_long, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: detects button presses, serves one at a time, classifies short/long, emits events
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   btn_db_i       debounced button levels, 1 = pressed
//   evt            event channel (master side): valid/ready/id/long
//   pause_state_o  toggles on accepted short event of PAUSE_ID
//   busy_o         high whenever the FSM is not idle
//   ovf_o          one-cycle pulse when a press coalesces into an already pending request
// Optional feature: define BTN_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (default is fixed priority, lowest index first).
module button_event_arbiter #(
    parameter int NUM_BTN     = 4,
    parameter int ID_W        = 2,
    parameter int CNT_W       = 27,
    parameter int LONG_CYCLES = 100000000,
    parameter int PAUSE_ID    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_BTN-1:0]    btn_db_i,
    button_event_arbiter_if.master evt,
    output logic                  pause_state_o,
    output logic                  busy_o,
    output logic                  ovf_o
);
    typedef enum logic [1:0] {IDLE, TRACK, EMIT, WAIT_REL} state_t;

    state_t               state_q, state_d;
    logic [NUM_BTN-1:0]   prev_q, prev_d;
    logic [NUM_BTN-1:0]   pending_q, pending_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 long_q, long_d;
    logic                 pause_q, pause_d;
    logic                 ovf_q, ovf_d;
    logic [NUM_BTN-1:0]   rise;
    logic [NUM_BTN-1:0]   clr;
    logic [ID_W-1:0]      sel;

    assign rise = btn_db_i & ~prev_q;

`ifdef BTN_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_q, last_d;
    // Walk backwards from the farthest candidate so the nearest one after last grant wins.
    always_comb begin
        sel = '0;
        for (int k = NUM_BTN - 1; k >= 0; k--)
            if (pending_q[(int'(last_q) + 1 + k) % NUM_BTN])
                sel = ID_W'((int'(last_q) + 1 + k) % NUM_BTN);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) last_q <= ID_W'(NUM_BTN - 1);
        else     last_q <= last_d;
`else
    // Lowest pending index wins.
    always_comb begin
        sel = '0;
        for (int k = NUM_BTN - 1; k >= 0; k--)
            if (pending_q[k]) sel = ID_W'(k);
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        long_d  = long_q;
        pause_d = pause_q;
        clr     = '0;
`ifdef BTN_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_d  = sel;
                    clr[sel] = 1'b1;
                    cnt_d    = '0;
                    state_d  = TRACK;
`ifdef BTN_ARB_ROUND_ROBIN_EN
                    last_d   = sel;
`endif
                end
            end
            TRACK: begin
                // Release wins over reaching the long threshold on the same cycle.
                if (!btn_db_i[grant_q]) begin
                    long_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else if (cnt_q == CNT_W'(LONG_CYCLES - 1)) begin
                    long_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EMIT: begin
                if (evt.evt_ready) begin
                    valid_d = 1'b0;
                    state_d = long_q ? WAIT_REL : IDLE;
                    pause_d = (!long_q && grant_q == ID_W'(PAUSE_ID)) ? ~pause_q : pause_q;
                end
            end
            WAIT_REL: state_d = btn_db_i[grant_q] ? WAIT_REL : IDLE;
            default:  state_d = IDLE;
        endcase
        // A rise on the same edge as the grant is kept as a fresh request.
        pending_d = (pending_q & ~clr) | rise;
        prev_d    = btn_db_i;
        ovf_d     = |(rise & pending_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= '1;
            pending_q <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            long_q    <= 1'b0;
            pause_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            long_q    <= long_d;
            pause_q   <= pause_d;
            ovf_q     <= ovf_d;
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_id    = grant_q;
    assign evt.evt_long  = long_q;
    assign pause_state_o = pause_q;
    assign busy_o        = (state_q != IDLE);
    assign ovf_o         = ovf_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed bench for button_event_arbiter with LONG_CYCLES=8
module tb_button_event_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic       pause, busy, ovf;
    int         n_chk = 0;
    int         n_err = 0;

`ifdef BTN_ARB_ROUND_ROBIN_EN
    localparam logic [1:0] O0 = 2'd3, O1 = 2'd0, O2 = 2'd1;
`else
    localparam logic [1:0] O0 = 2'd1, O1 = 2'd0, O2 = 2'd3;
`endif

    button_event_arbiter_if #(.ID_W(2)) evt();

    button_event_arbiter #(.LONG_CYCLES(8)) dut (
        .clk(clk),
        .rst(rst),
        .btn_db_i(btn),
        .evt(evt),
        .pause_state_o(pause),
        .busy_o(busy),
        .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press_short(int i);
        btn[i] = 1'b1;
        tick();
        tick();
        btn[i] = 1'b0;
        tick();
    endtask

    initial begin
        evt.evt_ready = 1'b0;
        tick(2);
        chk("rst_valid", evt.evt_valid, 0);
        chk("rst_id", evt.evt_id, 0);
        chk("rst_long", evt.evt_long, 0);
        chk("rst_pause", pause, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // short press of button 2, held for 3 cycles
        evt.evt_ready = 1'b1;
        btn = 4'b0100;
        tick();
        chk("t1_busy_pend", busy, 0);
        tick();
        chk("t1_busy_grant", busy, 1);
        tick();
        btn = 4'b0000;
        tick();
        chk("t1_valid", evt.evt_valid, 1);
        chk("t1_id", evt.evt_id, 2);
        chk("t1_long", evt.evt_long, 0);
        tick();
        chk("t1_valid_done", evt.evt_valid, 0);
        chk("t1_busy_done", busy, 0);
        chk("t1_pause", pause, 0);

        // long press of button 0
        btn = 4'b0001;
        tick(2);
        tick(7);
        chk("t2_valid_early", evt.evt_valid, 0);
        tick();
        chk("t2_valid", evt.evt_valid, 1);
        chk("t2_id", evt.evt_id, 0);
        chk("t2_long", evt.evt_long, 1);
        tick();
        chk("t2_valid_done", evt.evt_valid, 0);
        chk("t2_busy_hold", busy, 1);
        tick(5);
        chk("t2_busy_hold2", busy, 1);
        btn = 4'b0000;
        tick();
        chk("t2_busy_rel", busy, 0);
        tick(3);
        chk("t2_no_second", evt.evt_valid, 0);

        // pause toggling through button 1
        press_short(1);
        chk("t3_id_a", evt.evt_id, 1);
        tick();
        chk("t3_pause_a", pause, 1);
        press_short(1);
        tick();
        chk("t3_pause_b", pause, 0);
        evt.evt_ready = 1'b0;
        press_short(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", evt.evt_valid, 1);
            chk("t3_hold_id", evt.evt_id, 1);
            chk("t3_hold_long", evt.evt_long, 0);
            chk("t3_hold_pause", pause, 0);
        end
        evt.evt_ready = 1'b1;
        tick();
        chk("t3_valid_done", evt.evt_valid, 0);
        chk("t3_pause_c", pause, 1);

        // arbitration order: buttons 3 and 1 together, then 0 while serving
        evt.evt_ready = 1'b0;
        btn = 4'b1010;
        tick(2);
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        tick();
        chk("t4_valid0", evt.evt_valid, 1);
        chk("t4_id0", evt.evt_id, O0);
        evt.evt_ready = 1'b1;
        tick(3);
        chk("t4_valid1", evt.evt_valid, 1);
        chk("t4_id1", evt.evt_id, O1);
        tick(3);
        chk("t4_valid2", evt.evt_valid, 1);
        chk("t4_id2", evt.evt_id, O2);
        tick();
        chk("t4_busy_done", busy, 0);
        chk("t4_pause", pause, 0);

        // coalesced re-presses of button 2 while button 0 is tracked
        btn = 4'b0001;
        tick(2);
        btn = 4'b0101;
        tick();
        chk("t5_ovf_first", ovf, 0);
        btn = 4'b0001;
        tick();
        btn = 4'b0101;
        tick();
        chk("t5_ovf_pulse", ovf, 1);
        tick();
        chk("t5_ovf_clear", ovf, 0);
        btn = 4'b0000;
        tick();
        chk("t5_valid0", evt.evt_valid, 1);
        chk("t5_id0", evt.evt_id, 0);
        chk("t5_long0", evt.evt_long, 0);
        tick(3);
        chk("t5_valid2", evt.evt_valid, 1);
        chk("t5_id2", evt.evt_id, 2);
        tick(3);
        chk("t5_only_one", evt.evt_valid, 0);
        chk("t5_busy", busy, 0);

        press_short(1);
        tick();
        chk("t6_pause_pre", pause, 1);

        // button 3 held through reset, then reset during EMIT
        btn = 4'b1000;
        rst = 1'b1;
        tick(2);
        chk("t6_pause_rst", pause, 0);
        rst = 1'b0;
        tick(3);
        chk("t6_no_evt_busy", busy, 0);
        chk("t6_no_evt_valid", evt.evt_valid, 0);
        btn = 4'b0000;
        tick();
        evt.evt_ready = 1'b0;
        btn = 4'b1000;
        tick(2);
        btn = 4'b0010;
        tick();
        chk("t6_valid", evt.evt_valid, 1);
        chk("t6_id", evt.evt_id, 3);
        rst = 1'b1;
        btn = 4'b0000;
        #1;
        chk("t6_rst_valid", evt.evt_valid, 0);
        chk("t6_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        evt.evt_ready = 1'b1;
        tick(4);
        chk("t6_pend_busy", busy, 0);
        chk("t6_pend_valid", evt.evt_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
